iter_divider: RTL and testbench
===============================

# iter_divider

Multi-cycle divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions. It is the responder on a valid/ready request/response interface driven by the EX stage. It replaces the single-cycle combinational divide path with a radix-2 restoring divider that produces one quotient bit per cycle. The EX stage stalls the pipeline while a request is outstanding.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  single clock for the block. All state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  synchronous abort from pipeline control.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request. High only in IDLE with flush low.
- req_op  in  5  operation code, using the ALUControl encoding: 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- req_a  in  32  dividend (rs1).
- req_b  in  32  divisor (rs2).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  32  quotient or remainder.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, DIV, FIX, DONE.
- **IDLE**
  - A request is accepted when req_valid && req_ready.
  - On accept, latch the op and a sign flag (signed ops only). Latch |a| and |b|, computed in 32-bit two's complement.
  - Special cases go straight to DONE:
    - Divisor zero: quotient 0xFFFFFFFF, remainder = req_a.
    - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM only): quotient 0x80000000, remainder 0.
    - Opcode outside 10100–10111: result 0.
  - Otherwise go to DIV with the iteration counter set to 31.
- **DIV**
  - Each cycle, shift the {remainder, quotient} pair left by 1 and bring in the next dividend bit.
  - Trial subtraction is 33 bits wide. If the difference is non-negative, keep it and set the quotient LSB to 1.
  - Decrement the counter. After the cycle in which the counter is 0, go to FIX. This gives exactly 32 DIV cycles.
- **FIX**
  - Signed ops: negate the quotient if sign(a) XOR sign(b). The remainder takes the sign of a.
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU) into the result register.
  - Go to DONE.
- **DONE**
  - rsp_valid is high. Hold rsp_result stable until rsp_ready.
  - When rsp_ready is high, go to IDLE.
  - No new request is accepted in the same cycle as the handoff.
- **flush**: In any state, the next state is IDLE, any pending response is discarded, and rsp_valid drops on the next cycle. flush has priority over acceptance: req_ready is low while flush is high.
- **rst**: Same effect as flush. The result register and counter also clear to 0.

## Timing
- Reset values:
  - req_ready = 1 after the reset cycle. While rst is high, req_ready is 0.
  - rsp_valid = 0, busy = 0, rsp_result = 0.
- Normal latency, with acceptance at edge T:
  - DIV occupies cycles T+1 through T+32.
  - FIX occupies cycle T+33.
  - rsp_valid rises at T+34.
- Special-case latency: rsp_valid rises at T+1.
- Throughput: one op per 35 cycles minimum. There is one IDLE cycle between a response handoff and the next acceptance.
- rsp_result is registered, with no combinational path from inputs to outputs.
- req_* inputs are only sampled on acceptance. Changes during busy are ignored.

## Structure
- A shared package or header holds:
  - Localparams for the four M-extension divide opcodes.
  - The FSM state encoding (2 bits).
  - The special-case result constants: 0xFFFFFFFF and 0x80000000.
- One sub-module, div_step: a combinational single restoring step.
  - Inputs: 32-bit partial remainder, incoming bit, 32-bit divisor.
  - Outputs: next remainder and quotient bit.
  - It is instantiated once and used iteratively.
- The FSM, the counter, sign handling and the handshake live in iter_divider.

## Test plan
- **Basic DIV:** DIV a=100, b=7 → rsp_result 14. rsp_valid exactly 34 cycles after accept.
- **Signed REM and DIV:** REM a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFF (-1). DIV with the same operands → 0xFFFFFFFD (-3).
- **Unsigned DIVU and REMU:** DIVU a=0xFFFFFFFF, b=1 → 0xFFFFFFFF. REMU a=0xFFFFFFFF, b=0x10 → 0xF.
- **Division by zero:** DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5. Both respond one cycle after accept.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Both respond one cycle after accept.
- **Backpressure and flush:**
  - Hold rsp_ready low for 5 cycles in DONE. rsp_valid and rsp_result stay stable.
  - Assert flush at DIV cycle 10. busy drops next cycle, no response appears, and the next request is accepted in IDLE and produces a correct result.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared constants and types for the iterative RV32M divide/remainder unit.
// Opcodes follow the ALUControl encoding: bit 0 = unsigned, bit 1 = remainder.
package iter_divider_pkg;

    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    localparam logic [31:0] RES_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] RES_INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

    // Magnitude in 32-bit two's complement; INT_MIN maps to itself, which the
    // unsigned datapath then treats as 2^31.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in one
// dividend bit, and keep the trial difference when it does not go negative.
module div_step
    import iter_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor always holds, so a 33-bit difference is non-negative
    // exactly when its top bit is clear.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with a valid/ready request
// and response; one quotient bit per cycle, 32 iterations plus a sign fix-up.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    div_state_t state_q, state_d;

    logic            sel_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      cnt_q;

    logic            accept;
    logic            req_signed;
    logic            bad_op;
    logic            div_by_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // req_ready is low during rst/flush so an abort always wins over an accept.
    assign req_ready  = (state_q == ST_IDLE) && !flush && !rst;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_result = result_q;

    always_comb begin
        req_signed  = !req_op[0];
        bad_op      = !is_div_op(req_op);
        div_by_zero = (req_b == '0);
        sgn_ovf     = req_signed && (req_a == RES_INT_MIN) && (req_b == RES_ALL_ONES);
        special     = bad_op || div_by_zero || sgn_ovf;
        abs_a       = abs_if(req_a, req_signed);
        abs_b       = abs_if(req_b, req_signed);

        special_result = '0;
        if (bad_op) begin
            special_result = '0;
        end else if (div_by_zero) begin
            special_result = req_op[1] ? req_a : RES_ALL_ONES;
        end else if (sgn_ovf) begin
            special_result = req_op[1] ? '0 : RES_INT_MIN;
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[XLEN-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        quo_fixed = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fixed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_DIV;
            ST_DIV:  if (cnt_q == 5'd0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The quotient register starts as |a|; its MSB feeds the step each cycle
    // while the new quotient bit shifts in at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= 5'd0;
        end else begin
            if (accept) begin
                sel_rem_q <= req_op[1];
                neg_quo_q <= req_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                neg_rem_q <= req_signed && req_a[XLEN-1];
                rem_q     <= '0;
                quo_q     <= abs_a;
                dvs_q     <= abs_b;
                cnt_q     <= 5'd31;
                if (special) result_q <= special_result;
            end
            if (state_q == ST_DIV && !flush) begin
                rem_q <= step_rem;
                quo_q <= {quo_q[XLEN-2:0], step_q};
                cnt_q <= cnt_q - 5'd1;
            end
            if (state_q == ST_FIX && !flush) begin
                result_q <= sel_rem_q ? rem_fixed : quo_fixed;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latencies, special cases,
// response backpressure and flush abort.
module tb_iter_divider;
    import iter_divider_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    iter_divider #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_op = 5'd0;
        req_a = 32'h0;
        req_b = 32'h0;
    endtask

    // Latency counts edges after acceptance until rsp_valid is sampled high.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bit ok;
        issue(op, a, b, ok);
        if (!ok) begin
            lat = -1;
            res = 32'hxxxx_xxxx;
            return;
        end
        wait_rsp(lat);
        res = rsp_result;
        if (rsp_valid) handoff();
    endtask

    task automatic run_table(input string name, input vec_t v[]);
        logic [31:0] r;
        int          l;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, r, l);
            tests_run++;
            if (r !== v[i].exp) begin
                tests_failed++;
                $display("FAIL %s[%0d] result op=%b a=%h b=%h got %h want %h",
                         name, i, v[i].op, v[i].a, v[i].b, r, v[i].exp);
            end
            tests_run++;
            if (l !== v[i].lat) begin
                tests_failed++;
                $display("FAIL %s[%0d] latency got %0d want %0d", name, i, l, v[i].lat);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_ready got %b want 0", req_ready);
        end
        tests_run++;
        if ({rsp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_valid_busy got %b want 00", {rsp_valid, busy});
        end
        tests_run++;
        if (rsp_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result got %h want 00000000", rsp_result);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got %b want 1", req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_div;
        vec_t v[];
        v = new[2];
        v[0] = '{OP_DIV, 32'd100, 32'd7, 32'd14, 34};
        v[1] = '{OP_REMU, 32'd100, 32'd7, 32'd2, 34};
        run_table("basic", v);
    endtask

    task automatic test_signed;
        vec_t v[];
        v = new[7];
        v[0] = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
        v[1] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
        v[2] = '{OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34};
        v[3] = '{OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34};
        v[4] = '{OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34};
        v[5] = '{OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34};
        v[6] = '{OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34};
        run_table("signed", v);
    endtask

    task automatic test_unsigned;
        vec_t v[];
        v = new[4];
        v[0] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34};
        v[1] = '{OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34};
        v[2] = '{OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34};
        v[3] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34};
        run_table("unsigned", v);
    endtask

    task automatic test_div_zero;
        vec_t v[];
        v = new[4];
        v[0] = '{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        v[1] = '{OP_REM, 32'd5, 32'd0, 32'd5, 1};
        v[2] = '{OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1};
        v[3] = '{OP_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1};
        run_table("divzero", v);
    endtask

    task automatic test_overflow;
        vec_t v[];
        v = new[3];
        v[0] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[1] = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
        v[2] = '{5'b00000, 32'd7, 32'd3, 32'h0, 1};
        run_table("overflow_badop", v);
    endtask

    task automatic test_backpressure;
        bit ok;
        int l;
        int bad;
        issue(OP_DIVU, 32'd1000, 32'd10, ok);
        wait_rsp(l);
        tests_run++;
        if (!ok || l !== 34) begin
            tests_failed++;
            $display("FAIL bp_latency got %0d want 34 (accepted=%0d)", l, ok);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd100 || req_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (bad != 0 || rsp_valid !== 1'b1 || rsp_result !== 32'd100) begin
            tests_failed++;
            $display("FAIL bp_hold got %0d unstable cycles (valid=%b result=%h) want 0 (1, 00000064)",
                     bad, rsp_valid, rsp_result);
        end
        handoff();
        tests_run++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL bp_after_handoff valid/busy/ready got %b want 001",
                     {rsp_valid, busy, req_ready});
        end
    endtask

    task automatic test_flush;
        bit ok;
        int seen;
        logic [31:0] r;
        int l;
        issue(OP_DIV, 32'd1000, 32'd7, ok);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (!ok || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pre_busy got %b want 1 (accepted=%0d)", busy, ok);
        end
        flush = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_req_ready got %b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests_run++;
        if ({busy, rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_abort busy/valid got %b want 00", {busy, rsp_valid});
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_no_response got %0d active cycles want 0", seen);
        end
        run_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, r, l);
        tests_run++;
        if (r !== 32'hFFFF_FEB3 || l !== 34) begin
            tests_failed++;
            $display("FAIL flush_next_op got %h lat %0d want FFFFFEB3 lat 34", r, l);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_op = 5'd0;
        req_a = 32'h0;
        req_b = 32'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic_div();
        test_signed();
        test_unsigned();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
